// File: rtl/dmem_lsu_ctrl.sv
// Load/store controller: checks alignment, lane-aligns store data, runs one
// handshaked bus access per core request and returns extended load data.
module dmem_lsu_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [XLEN-1:0] core_addr,
    input  logic [1:0]      core_swhb,
    input  logic            core_lunsig,
    input  logic [XLEN-1:0] core_wdata,
    input  logic [3:0]      amp,
    output logic [XLEN-1:0] core_rdata,
    output logic            core_done,
    output logic            core_err,
    output logic            stall,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic              core_done_q, core_done_d;
    logic              core_err_q, core_err_d;
    logic [XLEN-1:0]   core_rdata_q, core_rdata_d;
    logic [1:0]        swhb_q, swhb_d;
    logic              lunsig_q, lunsig_d;
    logic [1:0]        lane_q, lane_d;

    logic              misaligned;
    logic [XLEN-1:0]   st_aligned;
    logic [7:0]        rd_byte [4];
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_ext;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = bus_rdata[8*gi +: 8];
    end

    // Byte accesses are always aligned; swhb=00 is never legal.
    always_comb begin
        misaligned = (core_swhb == 2'b00) ||
                     (core_swhb == 2'b01 && core_addr[1:0] != 2'b00) ||
                     (core_swhb == 2'b10 && core_addr[0]);
        case (core_swhb)
            2'b11:   st_aligned = {(XLEN/8){core_wdata[7:0]}};
            2'b10:   st_aligned = {(XLEN/16){core_wdata[15:0]}};
            default: st_aligned = core_wdata;
        endcase
    end

    always_comb begin
        ld_byte = rd_byte[lane_q];
        ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (swhb_q)
            2'b11:   ld_ext = {{(XLEN-8){ld_byte[7] & ~lunsig_q}}, ld_byte};
            2'b10:   ld_ext = {{(XLEN-16){ld_half[15] & ~lunsig_q}}, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        swhb_d       = swhb_q;
        lunsig_d     = lunsig_q;
        lane_d       = lane_q;
        core_done_d  = 1'b0;
        core_err_d   = 1'b0;
        core_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    if (misaligned) begin
                        state_d     = ERR;
                        core_done_d = 1'b1;
                        core_err_d  = 1'b1;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = core_we;
                        bus_addr_d  = {core_addr[XLEN-1:2], 2'b00};
                        bus_be_d    = amp;
                        bus_wdata_d = st_aligned;
                        swhb_d      = core_swhb;
                        lunsig_d    = core_lunsig;
                        lane_d      = core_addr[1:0];
                    end
                end
            end
            REQ: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (bus_ack) begin
                    state_d      = RESP;
                    bus_req_d    = 1'b0;
                    core_done_d  = 1'b1;
                    core_rdata_d = bus_we_q ? '0 : ld_ext;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d     = ERR;
                    bus_req_d   = 1'b0;
                    core_done_d = 1'b1;
                    core_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            swhb_q       <= '0;
            lunsig_q     <= 1'b0;
            lane_q       <= '0;
            core_done_q  <= 1'b0;
            core_err_q   <= 1'b0;
            core_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            swhb_q       <= swhb_d;
            lunsig_q     <= lunsig_d;
            lane_q       <= lane_d;
            core_done_q  <= core_done_d;
            core_err_q   <= core_err_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    assign core_rdata = core_rdata_q;
    assign core_done  = core_done_q;
    assign core_err   = core_err_q;
    assign stall      = core_req & ~core_done_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule
